// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: routes one valid/ready stream to two FIFO-buffered outputs.
// Ports: clk/rst, mode, cnt_clr, s_* input stream, m0_*/m1_* outputs, cnt0/cnt1.
module stream_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic              cnt_clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sel,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] L_PINC = AW'(1);
    localparam logic [AW:0] L_OINC = (AW + 1)'(1);

    logic [DATA_W-1:0] r_mem [2][DEPTH];
    logic [AW-1:0]     r_wp  [2];
    logic [AW-1:0]     r_rp  [2];
    logic [AW:0]       r_occ [2];
    logic [CNT_W-1:0]  r_cnt [2];
    logic              r_toggle;

    logic       w_dest;
    logic [1:0] w_full;
    logic [1:0] w_valid;
    logic [1:0] w_ready;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic       w_acc;

    // The toggle only steers when mode=1, so s_sel is never looked at then.
    assign w_dest = mode ? r_toggle : s_sel;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_full[i]  = (r_occ[i] == L_FULL);
            w_valid[i] = (r_occ[i] != '0);
        end
    end

    assign w_ready = {m1_ready, m0_ready};

    // Ready depends only on registered occupancy of the chosen FIFO.
    assign s_ready = w_dest ? !w_full[1] : !w_full[0];
    assign w_acc   = s_valid && s_ready;
    assign w_push  = {w_acc && w_dest, w_acc && !w_dest};
    assign w_pop   = w_valid & w_ready;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wp[i]] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_occ[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_toggle <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_push[i]) begin
                    r_wp[i] <= r_wp[i] + L_PINC;
                end
                if (w_pop[i]) begin
                    r_rp[i] <= r_rp[i] + L_PINC;
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_occ[i] <= r_occ[i] + L_OINC;
                end else if (!w_push[i] && w_pop[i]) begin
                    r_occ[i] <= r_occ[i] - L_OINC;
                end
                // Clear wins over a same-cycle delivery; count saturates.
                if (cnt_clr) begin
                    r_cnt[i] <= '0;
                end else if (w_pop[i] && r_cnt[i] != '1) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            if (mode && w_acc) begin
                r_toggle <= !r_toggle;
            end
        end
    end

    assign m0_valid = w_valid[0];
    assign m1_valid = w_valid[1];
    assign m0_data  = r_mem[0][r_rp[0]];
    assign m1_data  = r_mem[1][r_rp[1]];
    assign cnt0     = r_cnt[0];
    assign cnt1     = r_cnt[1];

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: scoreboard bench for stream_demux_1to2.
// Drives after posedge, samples on negedge, models routing/occupancy/counters.
module tb_stream_demux_1to2;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          cnt_clr = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_sel = 1'b0;
    logic          m0_valid;
    logic          m0_ready = 1'b1;
    logic [DW-1:0] m0_data;
    logic          m1_valid;
    logic          m1_ready = 1'b1;
    logic [DW-1:0] m1_data;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            mocc0 = 0;
    int            mocc1 = 0;
    int            mcnt0 = 0;
    int            mcnt1 = 0;
    logic          mtog = 1'b0;

    stream_demux_1to2 #(
        .DATA_W(DW),
        .DEPTH (DP),
        .CNT_W (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .cnt_clr (cnt_clr),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sel   (s_sel),
        .m0_valid(m0_valid),
        .m0_ready(m0_ready),
        .m0_data (m0_data),
        .m1_valid(m1_valid),
        .m1_ready(m1_ready),
        .m1_data (m1_data),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );

    always #5 clk = !clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Monitor: state seen at negedge is what the next posedge acts on.
    always @(negedge clk) begin
        logic dest;
        logic acc;
        logic p0;
        logic p1;
        logic [DW-1:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
            mocc0 = 0;
            mocc1 = 0;
            mcnt0 = 0;
            mcnt1 = 0;
            mtog  = 1'b0;
        end else begin
            dest = mode ? mtog : s_sel;
            chk("s_ready", int'(s_ready),
                int'(dest ? (mocc1 != DP) : (mocc0 != DP)));
            chk("m0_valid", int'(m0_valid), int'(mocc0 != 0));
            chk("m1_valid", int'(m1_valid), int'(mocc1 != 0));
            chk("cnt0", int'(cnt0), mcnt0);
            chk("cnt1", int'(cnt1), mcnt1);
            acc = s_valid && s_ready;
            p0  = m0_valid && m0_ready;
            p1  = m1_valid && m1_ready;
            if (p0) begin
                chk("m0_qnonempty", int'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("m0_data", int'(m0_data), int'(e));
                end
                mocc0--;
            end
            if (p1) begin
                chk("m1_qnonempty", int'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("m1_data", int'(m1_data), int'(e));
                end
                mocc1--;
            end
            if (acc) begin
                if (dest) begin
                    q1.push_back(s_data);
                    mocc1++;
                end else begin
                    q0.push_back(s_data);
                    mocc0++;
                end
                if (mode) mtog = !mtog;
            end
            if (cnt_clr) begin
                mcnt0 = 0;
                mcnt1 = 0;
            end else begin
                if (p0 && mcnt0 != 15) mcnt0++;
                if (p1 && mcnt1 != 15) mcnt1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic sel);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_sel   = sel;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("send_timeout", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        tick();
        chk("drain", q0.size() + q1.size(), 0);
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_m0_valid", int'(m0_valid), 0);
        chk("rst_m1_valid", int'(m1_valid), 0);
        chk("rst_s_ready", int'(s_ready), 1);
        chk("rst_cnt0", int'(cnt0), 0);
        tick();

        // Tagged routing
        mode = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        send(8'hA3, 1'b0);
        drain();
        @(negedge clk);
        chk("tag_cnt0", int'(cnt0), 2);
        chk("tag_cnt1", int'(cnt1), 1);
        tick();

        // De-interleave
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
        drain();
        send(8'h14, 1'b1);
        drain();
        @(negedge clk);
        chk("dei_cnt0", int'(cnt0), 3);
        chk("dei_cnt1", int'(cnt1), 2);
        tick();

        // Full / backpressure
        do_reset();
        mode     = 1'b0;
        m0_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h55;
        s_sel   = 1'b0;
        @(negedge clk);
        chk("full_sready", int'(s_ready), 0);
        tick();
        s_data = 8'h66;
        s_sel  = 1'b1;
        @(negedge clk);
        chk("sel1_nostall", int'(s_ready), 1);
        tick();
        s_data   = 8'h55;
        s_sel    = 1'b0;
        m0_ready = 1'b1;
        @(negedge clk);
        chk("full_still", int'(s_ready), 0);
        tick();
        m0_ready = 1'b0;
        @(negedge clk);
        chk("sready_back", int'(s_ready), 1);
        tick();
        s_valid = 1'b0;
        drain();

        // Simultaneous push/pop at occupancy 2
        m0_ready = 1'b0;
        send(8'h20, 1'b0);
        send(8'h21, 1'b0);
        m0_ready = 1'b1;
        s_valid  = 1'b1;
        s_sel    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_data = 8'(8'h30 + i);
            @(negedge clk);
            chk("pp_sready", int'(s_ready), 1);
            tick();
        end
        s_valid = 1'b0;
        drain();

        // Counter saturation and clear priority
        do_reset();
        for (int i = 0; i < 17; i++) send(8'(8'h80 + i), 1'b1);
        drain();
        @(negedge clk);
        chk("sat_cnt1", int'(cnt1), 15);
        tick();
        m1_ready = 1'b0;
        send(8'hC0, 1'b1);
        m1_ready = 1'b1;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_cnt1", int'(cnt1), 0);
        tick();

        // Reset mid-stream
        do_reset();
        mode     = 1'b1;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'(8'hD0 + i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_m0_valid", int'(m0_valid), 0);
        chk("mid_cnt0", int'(cnt0), 0);
        chk("mid_s_ready", int'(s_ready), 1);
        tick();
        send(8'hE7, 1'b1);
        @(negedge clk);
        chk("mid_to_m0", int'(m0_valid), 1);
        chk("mid_not_m1", int'(m1_valid), 0);
        chk("mid_data", int'(m0_data), 8'hE7);
        tick();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Inverse of the team's 2:1 selector: takes one valid/ready input stream and routes each beat to one of two buffered output streams.
- The destination comes from either a per-beat select tag or automatic alternation, which de-interleaves an even/odd stream.
- Each output has its own FIFO and a saturating delivered-beat counter.
- Sits between a shared datapath and two independent consumers.

Parameters:
- DATA_W, 8, width of the data path.
- DEPTH, 4, entries per output FIFO; must be a power of 2 and at least 2.
- CNT_W, 16, width of each delivered-beat counter.

Ports:
- clk  input  1  sole clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = tagged routing using s_sel; 1 = alternate routing using the internal toggle.
- cnt_clr  input  1  synchronous clear of both counters.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat can be accepted.
- s_data  input  DATA_W  input payload.
- s_sel  input  1  destination tag, used only when mode=0.
- m0_valid  output  1  output 0 has data.
- m0_ready  input  1  output 0 consumer ready.
- m0_data  output  DATA_W  output 0 payload.
- m1_valid  output  1  output 1 has data.
- m1_ready  input  1  output 1 consumer ready.
- m1_data  output  DATA_W  output 1 payload.
- cnt0  output  CNT_W  beats delivered on output 0.
- cnt1  output  CNT_W  beats delivered on output 1.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset state:
  - Both FIFOs empty; pointers and occupancy are 0.
  - toggle = 0; cnt0 = cnt1 = 0.
  - m0_valid = m1_valid = 0; s_ready = 1 (both FIFOs empty).
  - m*_data are don't-care while m*_valid = 0.
- Destination:
  - dest = s_sel when mode=0.
  - dest = toggle when mode=1.
- Input handshake:
  - s_ready = NOT full(dest FIFO).
  - full is the registered occupancy == DEPTH.
  - s_ready never depends combinationally on m0_ready or m1_ready.
  - s_ready may depend combinationally on s_sel and mode.
  - A beat is accepted when s_valid && s_ready at the rising edge; it is written to the dest FIFO.
- Toggle:
  - In mode=1 it flips on every accepted beat.
  - In mode=0 it holds its value.
  - Changing mode does not reset it.
- Output side:
  - Each FIFO is first-word fall-through from registered storage.
  - mX_valid = occupancy != 0.
  - mX_data = entry at the read pointer.
  - A pop occurs when mX_valid && mX_ready.
  - mX_data and mX_valid stay stable while mX_valid && !mX_ready.
- Latency: a beat accepted at edge N gives mX_valid = 1 in the cycle after edge N. There is no combinational s→m path.
- Simultaneous push and pop on the same FIFO:
  - Occupancy stays the same; both pointers advance.
  - When full, push is not possible that cycle because s_ready was 0; the pop frees a slot for the next cycle.
- Ordering:
  - Per-output order matches input acceptance order.
  - No beat is dropped or duplicated.
  - Outputs drain independently; a stalled output only blocks input beats destined for it.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Counters:
  - cntX increments by 1 on each output pop.
  - Saturates at 2^CNT_W − 1.
  - cnt_clr forces both to 0 and takes priority over a same-cycle increment.
  - rst forces both to 0.
- Reset during traffic: all buffered beats are discarded. From the next cycle the outputs are as in the reset state, and in-flight handshakes are ignored.
- X-safety: s_sel is ignored when mode=1, and s_data is ignored when s_valid=0.

Test Plan:
- Tagged routing: mode=0; send 0xA1(sel0), 0xB2(sel1), 0xA3(sel0); both readys high → m0 emits 0xA1 then 0xA3, m1 emits 0xB2, each one cycle after acceptance; cnt0=2, cnt1=1.
- De-interleave: mode=1 after reset; send 0x10, 0x11, 0x12, 0x13 back-to-back → m0 gets 0x10, 0x12; m1 gets 0x11, 0x13; toggle ends at 0.
- Full/backpressure: DEPTH=4, m0_ready=0; send 5 beats with sel0 → 4 accepted, s_ready=0 on the 5th. Raise m0_ready for one cycle → s_ready returns the next cycle, and the 5th beat is accepted. Meanwhile a sel1 beat is accepted with no stall.
- Simultaneous push/pop at occupancy 2 for 10 cycles → occupancy stays 2, data order preserved, no loss.
- Counters: CNT_W=4; deliver 17 beats on m1 → cnt1 saturates at 15. Pulse cnt_clr in the same cycle as a pop → cnt1=0.
- Reset mid-stream: 3 beats buffered in m0 and toggle=1, then assert rst for one cycle → next cycle m0_valid=0, cnt0=0, s_ready=1; the next mode=1 beat goes to m0.
